rv32i_memory_responder: RTL



---
 rtl/rv32i_memory_responder_pkg.sv | 42 ++++
 rtl/rv32i_memory_responder_mmio_timer.sv | 59 +++++
 rtl/rv32i_memory_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/rv32i_memory_responder_pkg.sv
// Shared MMIO map and address decode for the rv32i memory responder.
// Bit 31 of the byte address splits RAM space from the peripheral window.
package rv32i_memory_responder_pkg;

    localparam int MMIO_BASE_BIT = 31;

    localparam logic [7:0] MMIO_LEDS     = 8'h00;
    localparam logic [7:0] MMIO_MTIME    = 8'h04;
    localparam logic [7:0] MMIO_MTIMECMP = 8'h08;
    localparam logic [7:0] MMIO_STATUS   = 8'h0C;

    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_BERR_BIT = 1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LEDS,
        SEL_MTIME,
        SEL_MTIMECMP,
        SEL_STATUS,
        SEL_NONE
    } sel_e;

    // word is the byte address with bits [1:0] dropped; depth is the RAM size in words
    function automatic sel_e decode_addr(input logic [29:0] word, input logic [29:0] depth);
        sel_e sel;
        sel = SEL_NONE;
        if (!word[MMIO_BASE_BIT-2]) begin
            sel = ({1'b0, word[28:0]} < depth) ? SEL_RAM : SEL_NONE;
        end else if (word[28:6] == '0) begin
            case ({word[5:0], 2'b00})
                MMIO_LEDS:     sel = SEL_LEDS;
                MMIO_MTIME:    sel = SEL_MTIME;
                MMIO_MTIMECMP: sel = SEL_MTIMECMP;
                MMIO_STATUS:   sel = SEL_STATUS;
                default:       sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv32i_memory_responder_mmio_timer.sv
// mmio_timer: tick divider, free-running MTIME, MTIMECMP and the sticky pending bit.
// Only instantiated when MEMORY_RESPONDER_TIMER_EN is defined.
module mmio_timer
    import rv32i_memory_responder_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_wr,
    input  logic        mtimecmp_wr,
    input  logic [31:0] wr_data,
    input  logic        pend_clr,
    output logic [31:0] mtime,
    output logic [31:0] mtimecmp,
    output logic        pending
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [31:0]      mtime_next;
    logic             match;

    assign tick       = (div == DIV_LAST);
    assign mtime_next = mtime + 32'd1;
    // A load replaces the tick, so it can never produce a match itself
    assign match      = tick && !mtime_wr && (mtime_next == mtimecmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            mtime    <= '0;
            mtimecmp <= 32'hFFFF_FFFF;
            pending  <= 1'b0;
        end else begin
            if (mtime_wr) begin
                mtime <= wr_data;
                div   <= '0;
            end else if (tick) begin
                mtime <= mtime_next;
                div   <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (mtimecmp_wr) begin
                mtimecmp <= wr_data;
            end
            if (match) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rv32i_memory_responder.sv
// Memory responder for the rv32i core: word RAM plus LED/timer/status MMIO window.
// Timer block is present only when MEMORY_RESPONDER_TIMER_EN is defined.
module rv32i_memory_responder
    import rv32i_memory_responder_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter     INIT_FILE = "",
    parameter int LED_W     = 8,
    parameter int TICK_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wr_data,
    input  logic             mem_wr_ena,
    output logic [31:0]      mem_rd_data,
    output logic [LED_W-1:0] leds,
    output logic             timer_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]      ram [DEPTH];
    sel_e             sel;
    logic [AW-1:0]    idx;
    logic [LED_W-1:0] leds_q;
    logic             berr;
    logic [31:0]      mtime;
    logic [31:0]      mtimecmp;
    logic             pending;
    logic             unused_bits;

    assign sel = decode_addr(mem_addr[31:2], 30'(DEPTH));
    assign idx = mem_addr[AW+1:2];
    assign unused_bits = ^{mem_addr[1:0], mem_wr_data, TICK_DIV};

    // RAM contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_wr_ena && sel == SEL_RAM) begin
            ram[idx] <= mem_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= '0;
            berr   <= 1'b0;
        end else if (mem_wr_ena) begin
            if (sel == SEL_LEDS) begin
                leds_q <= mem_wr_data[LED_W-1:0];
            end
            if (sel == SEL_NONE) begin
                berr <= 1'b1;
            end else if (sel == SEL_STATUS && mem_wr_data[STATUS_BERR_BIT]) begin
                berr <= 1'b0;
            end
        end
    end

`ifdef MEMORY_RESPONDER_TIMER_EN
    mmio_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .mtime_wr    (mem_wr_ena && sel == SEL_MTIME),
        .mtimecmp_wr (mem_wr_ena && sel == SEL_MTIMECMP),
        .wr_data     (mem_wr_data),
        .pend_clr    (mem_wr_ena && sel == SEL_STATUS && mem_wr_data[STATUS_PEND_BIT]),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .pending     (pending)
    );
`else
    assign mtime    = '0;
    assign mtimecmp = '0;
    assign pending  = 1'b0;
`endif

    // Pure decode: the core drives arbitrary addresses, so reads must never change state
    always_comb begin
        mem_rd_data = '0;
        case (sel)
            SEL_RAM:      mem_rd_data = ram[idx];
            SEL_LEDS:     mem_rd_data[LED_W-1:0] = leds_q;
            SEL_MTIME:    mem_rd_data = mtime;
            SEL_MTIMECMP: mem_rd_data = mtimecmp;
            SEL_STATUS: begin
                mem_rd_data[STATUS_PEND_BIT] = pending;
                mem_rd_data[STATUS_BERR_BIT] = berr;
            end
            default:      mem_rd_data = '0;
        endcase
    end

    assign leds      = leds_q;
    assign timer_irq = pending;

endmodule
